// File: rtl/bottling_pkg.sv
// Shared state encoding and default timing constants for the bottling line.
package bottling_pkg;
  localparam int FILL_TIMEOUT_DEF = 50;
  localparam int CAP_CYCLES_DEF   = 4;
  localparam int PACK_CYCLES_DEF  = 8;

  localparam logic [3:0] LAST_IN_DOZEN = 4'd11;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_ADVANCE = 3'd1;
  localparam state_t S_FILL    = 3'd2;
  localparam state_t S_CAP     = 3'd3;
  localparam state_t S_PACK    = 3'd4;
  localparam state_t S_FAULT   = 3'd5;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/bottling_ctrl_if.sv
// Line-side signals: operator/sensor inputs and actuator/status outputs.
interface bottling_ctrl_if;
  logic       start, stop, sensor_bottle, sensor_level, ack;
  logic       motor, valve, capper, gp, dozen, alarm;
  logic [3:0] bottle_cnt;

  modport master (
    output start, stop, sensor_bottle, sensor_level, ack,
    input  motor, valve, capper, gp, dozen, alarm, bottle_cnt
  );
  modport slave (
    input  start, stop, sensor_bottle, sensor_level, ack,
    output motor, valve, capper, gp, dozen, alarm, bottle_cnt
  );
endinterface

// File: rtl/ctrl_timer.sv
// Per-state cycle timer; tc flags the last cycle of a term-cycle residency.
module ctrl_timer
  import bottling_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == term - 1'b1);
endmodule

// File: rtl/bottling_ctrl.sv
// Bottling line sequencer: advance, fill, cap, and pause after each dozen.
module bottling_ctrl
  import bottling_pkg::*;
#(
  parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF,
  parameter int CAP_CYCLES   = CAP_CYCLES_DEF,
  parameter int PACK_CYCLES  = PACK_CYCLES_DEF
) (
  input logic            clk,
  input logic            reset,
  bottling_ctrl_if.slave bus
);
  localparam int TMAX = max3(FILL_TIMEOUT, CAP_CYCLES, PACK_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  state_t      st, nxt;
  logic        stop_q, stop_any, timed, tc, cap_done, gp_q, dozen_q;
  logic [3:0]  cnt;
  logic [TW-1:0] term;

  assign stop_any = stop_q | bus.stop;
  assign timed    = st inside {S_FILL, S_CAP, S_PACK};
  assign cap_done = (st == S_CAP) && tc;

  always_comb begin
    term = TW'(FILL_TIMEOUT);
    case (st)
      S_CAP:   term = TW'(CAP_CYCLES);
      S_PACK:  term = TW'(PACK_CYCLES);
      default: term = TW'(FILL_TIMEOUT);
    endcase
  end

  // sensor_level wins over the timeout; stop wins over a newly arrived bottle
  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:    if (bus.start) nxt = S_ADVANCE;
      S_ADVANCE: if (stop_any) nxt = S_IDLE;
                 else if (bus.sensor_bottle) nxt = S_FILL;
      S_FILL:    if (bus.sensor_level) nxt = S_CAP;
                 else if (tc) nxt = S_FAULT;
      S_CAP:     if (tc) nxt = (cnt == LAST_IN_DOZEN) ? S_PACK : S_ADVANCE;
      S_PACK:    if (tc) nxt = stop_any ? S_IDLE : S_ADVANCE;
      S_FAULT:   if (bus.ack) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  ctrl_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (nxt != st),
    .en    (timed),
    .term  (term),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_IDLE;
      stop_q  <= 1'b0;
      cnt     <= '0;
      gp_q    <= 1'b0;
      dozen_q <= 1'b0;
    end else begin
      st      <= nxt;
      gp_q    <= cap_done;
      dozen_q <= cap_done && (cnt == LAST_IN_DOZEN);
      if (cap_done) cnt <= (cnt == LAST_IN_DOZEN) ? 4'd0 : cnt + 4'd1;
      // a stop during a bottle or pack pause is held until the line is idle
      if (nxt == S_IDLE && st != S_IDLE) stop_q <= 1'b0;
      else if (bus.stop && timed)        stop_q <= 1'b1;
    end
  end

  assign bus.motor      = (st == S_ADVANCE);
  assign bus.valve      = (st == S_FILL);
  assign bus.capper     = (st == S_CAP);
  assign bus.alarm      = (st == S_FAULT);
  assign bus.gp         = gp_q;
  assign bus.dozen      = dozen_q;
  assign bus.bottle_cnt = cnt;
endmodule

// File: tb/tb_bottling_ctrl.sv
// Randomized scoreboard bench for bottling_ctrl with directed corner scenarios.
module tb_bottling_ctrl;
  import bottling_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bottling_ctrl_if bus();

  bottling_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed { logic dz; logic [3:0] cnt; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int m_cnt = 0, gp_seen = 0, bottles = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // every produced bottle must match the next expected completion in order
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.dozen) chk("dozen_with_gp", bus.gp, 1);
      if (bus.gp) begin
        gp_seen++;
        if (exp_q.size() == 0) chk("gp_unexpected_qdepth", exp_q.size(), 1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_dozen", bus.dozen, e.dz);
          chk("sb_bottle_cnt", bus.bottle_cnt, e.cnt);
        end
      end
    end
  end

  task automatic go();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_advance_motor", bus.motor, 1);
  endtask

  // one bottle from ADVANCE; ends in ADVANCE, or IDLE if stop was pulsed in CAP
  task automatic bottle(int adv_wait, int fill_n, bit stop_cap);
    int c;
    bit wrap;
    exp_t e;
    for (int i = 0; i < adv_wait; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      step();
    end
    bus.start = 1'b0;
    chk("adv_motor", bus.motor, 1);
    bus.sensor_bottle = 1'b1;
    step();
    bus.sensor_bottle = 1'b0;
    c = 0;
    for (int i = 1; i <= fill_n; i++) begin
      c += int'(bus.valve);
      bus.sensor_level = (i == fill_n);
      step();
    end
    bus.sensor_level = 1'b0;
    chk("fill_len", c, fill_n);
    wrap = (m_cnt == 11);
    m_cnt = (m_cnt + 1) % 12;
    e.dz = wrap;
    e.cnt = 4'(m_cnt);
    exp_q.push_back(e);
    bottles++;
    c = 0;
    for (int i = 1; i <= CAP_CYCLES_DEF; i++) begin
      c += int'(bus.capper);
      bus.stop = stop_cap && (i == 2);
      step();
    end
    bus.stop = 1'b0;
    chk("cap_len", c, CAP_CYCLES_DEF);
    chk("gp_after_cap", bus.gp, 1);
    chk("capper_off", bus.capper, 0);
    chk("alarm_off", bus.alarm, 0);
    if (wrap) begin
      chk("dozen_inline", bus.dozen, 1);
      c = 0;
      for (int i = 0; i < PACK_CYCLES_DEF; i++) begin
        c += int'(!bus.motor && !bus.valve && !bus.capper);
        step();
      end
      chk("pack_len", c, PACK_CYCLES_DEF);
      chk("after_pack_motor", bus.motor, stop_cap ? 0 : 1);
    end else begin
      chk("adv_after_cap", bus.motor, 1);
      if (stop_cap) begin
        bus.sensor_bottle = 1'b1;
        step();
        step();
        bus.sensor_bottle = 1'b0;
        chk("stop_idle_motor", bus.motor, 0);
        chk("stop_idle_valve", bus.valve, 0);
      end
    end
  endtask

  task automatic timeout_fault();
    int c;
    bus.sensor_bottle = 1'b1;
    step();
    bus.sensor_bottle = 1'b0;
    c = 0;
    for (int i = 0; i < FILL_TIMEOUT_DEF; i++) begin
      c += int'(bus.valve);
      step();
    end
    chk("timeout_fill_len", c, FILL_TIMEOUT_DEF);
    chk("fault_alarm", bus.alarm, 1);
    chk("fault_valve", bus.valve, 0);
    chk("fault_motor", bus.motor, 0);
    chk("fault_cnt_kept", bus.bottle_cnt, m_cnt);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("fault_ignores_start", bus.alarm, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.ack = 1'b0;
    bus.sensor_bottle = 1'b0; bus.sensor_level = 1'b0;
    step();
    step();
    chk("rst_motor", bus.motor, 0);
    chk("rst_valve", bus.valve, 0);
    chk("rst_capper", bus.capper, 0);
    chk("rst_gp", bus.gp, 0);
    chk("rst_dozen", bus.dozen, 0);
    chk("rst_alarm", bus.alarm, 0);
    chk("rst_cnt", bus.bottle_cnt, 0);
    reset = 1'b0;
    step();
    chk("idle_without_start", bus.motor, 0);

    // nominal bottle: sensor at ADVANCE cycle 3, level after 10 fill cycles
    go();
    bottle(2, 10, 1'b0);
    chk("nominal_cnt", bus.bottle_cnt, 1);

    // rest of the dozen, including a level arriving in the timeout cycle
    for (int i = 0; i < 10; i++)
      bottle($urandom_range(0, 4), (i == 4) ? FILL_TIMEOUT_DEF : $urandom_range(1, 20), 1'b0);
    chk("cnt_before_wrap", bus.bottle_cnt, 11);
    bottle($urandom_range(0, 4), $urandom_range(1, 20), 1'b0);
    chk("gp_count_dozen", gp_seen, 12);
    chk("cnt_after_wrap", bus.bottle_cnt, 0);

    for (int i = 0; i < 3; i++) bottle($urandom_range(0, 3), $urandom_range(1, 20), 1'b0);
    timeout_fault();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    chk("ack_alarm_clear", bus.alarm, 0);
    chk("ack_idle_motor", bus.motor, 0);
    chk("ack_cnt_kept", bus.bottle_cnt, m_cnt);
    step();
    chk("ack_stays_idle", bus.motor, 0);

    // stop beats a bottle arriving in the same ADVANCE cycle
    go();
    bus.stop = 1'b1;
    bus.sensor_bottle = 1'b1;
    step();
    bus.stop = 1'b0;
    bus.sensor_bottle = 1'b0;
    chk("adv_stop_prio_valve", bus.valve, 0);
    chk("adv_stop_prio_motor", bus.motor, 0);

    go();
    bottle(1, 5, 1'b1);

    // reset in the middle of a fill with five bottles counted
    go();
    while (m_cnt != 5) bottle($urandom_range(0, 3), $urandom_range(1, 15), 1'b0);
    bus.sensor_bottle = 1'b1;
    step();
    bus.sensor_bottle = 1'b0;
    chk("pre_reset_valve", bus.valve, 1);
    chk("pre_reset_cnt", bus.bottle_cnt, 5);
    step();
    reset = 1'b1;
    step();
    chk("midfill_rst_valve", bus.valve, 0);
    chk("midfill_rst_motor", bus.motor, 0);
    chk("midfill_rst_cnt", bus.bottle_cnt, 0);
    chk("midfill_rst_alarm", bus.alarm, 0);
    reset = 1'b0;
    m_cnt = 0;
    step();
    chk("post_rst_idle", bus.motor, 0);

    go();
    for (int i = 0; i < 25; i++) begin
      bit s;
      s = ($urandom_range(0, 4) == 0);
      bottle($urandom_range(0, 4), $urandom_range(1, FILL_TIMEOUT_DEF), s);
      if (s) go();
    end

    timeout_fault();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_cnt = 0;
    chk("fault_rst_alarm", bus.alarm, 0);
    chk("fault_rst_cnt", bus.bottle_cnt, 0);

    step();
    chk("queue_drained", exp_q.size(), 0);
    chk("gp_total", gp_seen, bottles);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
